// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter, hence the floor of one.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational one-bit full subtractor: Diff = a - b - c, Borrow is the
// borrow-out of that bit.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic Diff,
    output logic Borrow
);

    assign Diff   = a ^ b ^ c;
    assign Borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single full-subtractor cell with the borrow fed back through a register.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow_q;
    logic [CW-1:0]    count;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] diff_shift;

    full_subtractor_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .c      (borrow_q),
        .Diff   (d),
        .Borrow (bo)
    );

    // Result bits enter from the MSB side so the LSB lands at bit 0 last.
    always_comb begin
        diff_shift            = Diff >> 1;
        diff_shift[WIDTH-1]   = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            borrow_q <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= bin;
                        count    <= '0;
                        Diff     <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    Diff     <= diff_shift;
                    borrow_q <= bo;
                    count    <= count + CW'(1);
                    if (count == LAST) begin
                        Borrow <= bo;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
